// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 3;
    localparam int unsigned ZERO_IDX_DEF = 7;

    // Reserved indices for the planned system bank.
    localparam int unsigned PC_IDX   = 6;
    localparam int unsigned CPSR_IDX = 7;

    // LSB position of port 'port' inside a packed multi-port vector.
    function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy bits for hazard detection, with registered per-port busy reads.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr0_en,
    input  logic [ADDR_W-1:0]        clr0_addr,
    input  logic                     clr1_en,
    input  logic [ADDR_W-1:0]        clr1_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt_c;
    logic [NUM_RD-1:0] rd_busy_c;

    // A reservation beats a same-cycle write: the new producer owns the register.
    always_comb begin
        busy_nxt_c = busy;
        if (clr0_en) busy_nxt_c[clr0_addr] = 1'b0;
        if (clr1_en) busy_nxt_c[clr1_addr] = 1'b0;
        if (set_en)  busy_nxt_c[set_addr]  = 1'b1;
    end

    always_comb begin
        rd_busy_c = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (BYPASS)
                rd_busy_c[i] = busy_nxt_c[rd_addr[port_lsb(i, ADDR_W) +: ADDR_W]];
            else
                rd_busy_c[i] = busy[rd_addr[port_lsb(i, ADDR_W) +: ADDR_W]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= '0;
            rd_busy <= '0;
        end else begin
            busy    <= busy_nxt_c;
            rd_busy <= rd_busy_c;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file for the ID stage: registered reads, two write ports,
// hardwired zero register, optional write-to-read bypass and busy scoreboard.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_IDX = ZERO_IDX_DEF,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [ADDR_W-1:0]        br_addr,
    output logic [DATA_W-1:0]        br_data,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     wr_conflict
);

    localparam int unsigned       NREG      = 2 ** ADDR_W;
    localparam bit                ZERO_EN   = (ZERO_IDX < NREG);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

    logic [DATA_W-1:0]        regs [NREG];
    logic                     w0_c;
    logic                     w1_c;
    logic                     w0_commit_c;
    logic                     conflict_c;
    logic                     rsv_c;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [DATA_W-1:0]        br_data_c;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_EN && (a == ZERO_ADDR);
    endfunction

    // Writes and reserves aimed at the zero register are dropped here.
    assign w0_c        = wr0_en && !is_zero(wr0_addr);
    assign w1_c        = wr1_en && !is_zero(wr1_addr);
    assign conflict_c  = w0_c && w1_c && (wr0_addr == wr1_addr);
    assign w0_commit_c = w0_c && !conflict_c;
    assign rsv_c       = rsv_en && !is_zero(rsv_addr);

    function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a);
        if (is_zero(a))                                return '0;
        if (BYPASS && w1_c && (wr1_addr == a))         return wr1_data;
        if (BYPASS && w0_commit_c && (wr0_addr == a))  return wr0_data;
        return regs[a];
    endfunction

    always_comb begin
        rd_data_c = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_data_c[port_lsb(i, DATA_W) +: DATA_W] = read_val(rd_addr[port_lsb(i, ADDR_W) +: ADDR_W]);
        end
        br_data_c = read_val(br_addr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
            rd_data     <= '0;
            br_data     <= '0;
            wr_conflict <= 1'b0;
        end else begin
            if (w0_commit_c) regs[wr0_addr] <= wr0_data;
            if (w1_c)        regs[wr1_addr] <= wr1_data;
            rd_data     <= rd_data_c;
            br_data     <= br_data_c;
            wr_conflict <= conflict_c;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (rsv_c),
        .set_addr  (rsv_addr),
        .clr0_en   (w0_c),
        .clr0_addr (wr0_addr),
        .clr1_en   (w1_c),
        .clr1_addr (wr1_addr),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: bypass and non-bypass instances share stimulus,
// a behavioural model queues expected outputs that are checked one cycle later.
module tb_reg_file_mp;
    import regfile_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 3;
    localparam int unsigned NR   = 2;
    localparam int unsigned NREG = 8;
    localparam logic [AW-1:0] ZR = 3'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [NR*AW-1:0] rd_addr;
    logic [AW-1:0]    br_addr;
    logic             wr0_en, wr1_en, rsv_en;
    logic [AW-1:0]    wr0_addr, wr1_addr, rsv_addr;
    logic [DW-1:0]    wr0_data, wr1_data;

    logic [NR*DW-1:0] rd_data, rd_data_nb;
    logic [NR-1:0]    rd_busy, rd_busy_nb;
    logic [DW-1:0]    br_data, br_data_nb;
    logic             wr_conflict, wr_conflict_nb;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_IDX(7), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .br_addr(br_addr), .br_data(br_data),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_conflict(wr_conflict)
    );

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_IDX(7), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .br_addr(br_addr), .br_data(br_data_nb),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_conflict(wr_conflict_nb)
    );

    typedef struct packed {
        logic [NR*DW-1:0] rd_data;
        logic [NR-1:0]    rd_busy;
        logic [DW-1:0]    br_data;
        logic [NR*DW-1:0] rd_data_nb;
        logic [NR-1:0]    rd_busy_nb;
        logic [DW-1:0]    br_data_nb;
        logic             conflict;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_regs [NREG];
    logic [NREG-1:0] m_busy;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] mread(input logic [AW-1:0] a, input logic w0, input logic w1, input logic byp);
        if (a == ZR)                     return '0;
        if (byp && w1 && wr1_addr == a)  return wr1_data;
        if (byp && w0 && wr0_addr == a)  return wr0_data;
        return m_regs[a];
    endfunction

    // Reference behaviour for one clock edge; expected outputs are queued.
    task automatic push_expected();
        exp_t e;
        logic w0, w1;
        logic [AW-1:0] a;
        logic [NREG-1:0] nb;
        e = '0;
        if (rst_n) begin
            w0 = wr0_en && (wr0_addr != ZR);
            w1 = wr1_en && (wr1_addr != ZR);
            nb = m_busy;
            if (w0) nb[wr0_addr] = 1'b0;
            if (w1) nb[wr1_addr] = 1'b0;
            if (rsv_en && rsv_addr != ZR) nb[rsv_addr] = 1'b1;
            for (int i = 0; i < int'(NR); i++) begin
                a = rd_addr[i*AW +: AW];
                e.rd_data[i*DW +: DW]    = mread(a, w0, w1, 1'b1);
                e.rd_data_nb[i*DW +: DW] = mread(a, w0, w1, 1'b0);
                e.rd_busy[i]             = nb[a];
                e.rd_busy_nb[i]          = m_busy[a];
            end
            e.br_data    = mread(br_addr, w0, w1, 1'b1);
            e.br_data_nb = mread(br_addr, w0, w1, 1'b0);
            e.conflict   = w0 && w1 && (wr0_addr == wr1_addr);
            if (w0) m_regs[wr0_addr] = wr0_data;
            if (w1) m_regs[wr1_addr] = wr1_data;
            m_busy = nb;
        end else begin
            for (int r = 0; r < int'(NREG); r++) m_regs[r] = '0;
            m_busy = '0;
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        push_expected();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("rd_data",        64'(rd_data),        64'(e.rd_data));
        chk("rd_busy",        64'(rd_busy),        64'(e.rd_busy));
        chk("br_data",        64'(br_data),        64'(e.br_data));
        chk("wr_conflict",    64'(wr_conflict),    64'(e.conflict));
        chk("rd_data_nb",     64'(rd_data_nb),     64'(e.rd_data_nb));
        chk("rd_busy_nb",     64'(rd_busy_nb),     64'(e.rd_busy_nb));
        chk("br_data_nb",     64'(br_data_nb),     64'(e.br_data_nb));
        chk("wr_conflict_nb", 64'(wr_conflict_nb), 64'(e.conflict));
    endtask

    task automatic idle();
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        rsv_en = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    initial begin
        rst_n = 1'b0; rd_addr = '0; br_addr = '0;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        for (int r = 0; r < int'(NREG); r++) m_regs[r] = '0;
        m_busy = '0;

        // Reset, then sweep every address on all read ports.
        cycle();
        cycle();
        idle();
        for (int a = 0; a < int'(NREG); a++) begin
            set_rd(0, AW'(a)); set_rd(1, AW'(7 - a)); br_addr = AW'(a);
            cycle();
            chk("t1_rd_data_zero", 64'(rd_data), 64'd0);
            chk("t1_rd_busy_zero", 64'(rd_busy), 64'd0);
        end

        // Plain write then read; zero register ignores writes.
        wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 32'hDEADBEEF; set_rd(0, 3'd0);
        cycle();
        idle(); set_rd(0, 3'd3);
        cycle();
        chk("t2_r3", 64'(rd_data[0 +: DW]), 64'h0000_0000_DEAD_BEEF);
        wr1_en = 1'b1; wr1_addr = 3'd7; wr1_data = 32'h1234; set_rd(0, 3'd7);
        cycle();
        chk("t2_r7_bypass_zero", 64'(rd_data[0 +: DW]), 64'd0);
        idle();
        cycle();
        chk("t2_r7_zero", 64'(rd_data[0 +: DW]), 64'd0);

        // Same-cycle write and read: forwarded only on the bypass instance.
        wr0_en = 1'b1; wr0_addr = 3'd2; wr0_data = 32'hA5A5A5A5; set_rd(1, 3'd2); br_addr = 3'd2;
        cycle();
        chk("t3_rd1_byp", 64'(rd_data[DW +: DW]),    64'h0000_0000_A5A5_A5A5);
        chk("t3_br_byp",  64'(br_data),              64'h0000_0000_A5A5_A5A5);
        chk("t3_rd1_nb",  64'(rd_data_nb[DW +: DW]), 64'd0);
        chk("t3_br_nb",   64'(br_data_nb),           64'd0);
        idle();
        cycle();
        chk("t3_br_nb_later", 64'(br_data_nb), 64'h0000_0000_A5A5_A5A5);

        // Dual write to one register: wr1 wins and conflict pulses once.
        wr0_en = 1'b1; wr0_addr = 3'd4; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 3'd4; wr1_data = 32'h22; set_rd(0, 3'd4);
        cycle();
        chk("t4_conflict", 64'(wr_conflict), 64'd1);
        idle();
        cycle();
        chk("t4_conflict_pulse", 64'(wr_conflict), 64'd0);
        chk("t4_r4", 64'(rd_data[0 +: DW]), 64'h22);
        wr0_en = 1'b1; wr0_addr = 3'd7; wr1_en = 1'b1; wr1_addr = 3'd7;
        cycle();
        chk("t4_zero_no_conflict", 64'(wr_conflict), 64'd0);

        // Scoreboard set/clear interplay.
        idle(); rsv_en = 1'b1; rsv_addr = 3'd5; set_rd(0, 3'd5);
        cycle();
        chk("t5_busy_byp", 64'(rd_busy[0]),    64'd1);
        chk("t5_busy_nb",  64'(rd_busy_nb[0]), 64'd0);
        idle(); rsv_en = 1'b1; rsv_addr = 3'd5; wr0_en = 1'b1; wr0_addr = 3'd5; wr0_data = 32'h9;
        cycle();
        idle();
        cycle();
        chk("t5_busy_held", 64'(rd_busy[0]),       64'd1);
        chk("t5_data_9",    64'(rd_data[0 +: DW]), 64'h9);
        wr1_en = 1'b1; wr1_addr = 3'd5; wr1_data = 32'hA;
        cycle();
        idle();
        cycle();
        chk("t5_busy_clear", 64'(rd_busy[0]),       64'd0);
        chk("t5_data_a",     64'(rd_data[0 +: DW]), 64'hA);

        // Reset in the middle of activity discards the same-cycle write.
        rsv_en = 1'b1; rsv_addr = 3'd1;
        cycle();
        idle(); wr0_en = 1'b1; wr0_addr = 3'd1; wr0_data = 32'hFF; rsv_en = 1'b1; rsv_addr = 3'd6;
        cycle();
        wr0_data = 32'h55; rsv_addr = 3'd1; set_rd(0, 3'd1); set_rd(1, 3'd6); br_addr = 3'd1;
        rst_n = 1'b0;
        cycle();
        chk("t6_rst_data", 64'(rd_data), 64'd0);
        chk("t6_rst_br",   64'(br_data), 64'd0);
        idle();
        cycle();
        chk("t6_r1_zero",   64'(rd_data[0 +: DW]), 64'd0);
        chk("t6_busy_zero", 64'(rd_busy),          64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            rst_n    = ($urandom_range(0, 40) != 0);
            wr0_en   = 1'($urandom_range(0, 1));
            wr1_en   = 1'($urandom_range(0, 1));
            rsv_en   = 1'($urandom_range(0, 1));
            wr0_addr = AW'($urandom_range(0, 7));
            wr1_addr = AW'($urandom_range(0, 7));
            rsv_addr = AW'($urandom_range(0, 7));
            wr0_data = $urandom;
            wr1_data = $urandom;
            set_rd(0, AW'($urandom_range(0, 7)));
            set_rd(1, AW'($urandom_range(0, 7)));
            br_addr  = AW'($urandom_range(0, 7));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised successor to the 8x32 register file, built for the pipelined core's ID stage.
- Adds: NUM_RD registered read ports plus a dedicated branch-target read port, two write ports (ALU and load writeback), a hardwired zero register, optional write-to-read bypass, and a per-register busy scoreboard for hazard detection.
- All reads have 1-cycle registered latency.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 3, address width; depth NREG = 2**ADDR_W
NUM_RD, 2, number of general read ports (1..4)
ZERO_IDX, 7, index of hardwired-zero register; ZERO_IDX >= NREG disables the feature
BYPASS, 1, 1 = same-cycle write forwarded to read output; 0 = read returns pre-write value

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed registered read data
rd_busy  out  NUM_RD  registered busy flag of addressed register, per port
br_addr  in  ADDR_W  branch-target register address
br_data  out  DATA_W  registered branch-target value
wr0_en  in  1  write port 0 enable (ALU writeback)
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (load writeback)
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
rsv_en  in  1  reserve: mark rsv_addr busy (instruction issued with pending destination)
rsv_addr  in  ADDR_W  register to reserve
wr_conflict  out  1  registered pulse: both write ports hit the same non-zero register this cycle

Behaviour:
- One clock; reset is synchronous and active-low: on a clk edge with rst_n=0, all registers, busy bits, rd_data, rd_busy, br_data and wr_conflict go to 0. Reset overrides every other input that cycle.
- Reads: at each edge, rd_data[i] <= value(rd_addr[i]), rd_busy[i] <= busy(rd_addr[i]), br_data <= value(br_addr). Latency is exactly 1 cycle. Ports are independent, and any ports may share an address.
- Write resolution: a write commits at the edge.
  - wr0 and wr1 to the same address in the same cycle: wr1 wins, and wr_conflict=1 next cycle.
  - Otherwise both writes commit.
- Zero register (ZERO_IDX < NREG):
  - Reads always return 0 and busy 0.
  - Writes and reserves to it are ignored and never raise wr_conflict.
- Bypass (BYPASS=1): when a read address equals a committing write address in the same cycle, the read output gets the resolved write data (wr1 over wr0).
  - Applies to rd and br ports.
  - With BYPASS=0, the read returns the old contents.
- Scoreboard (NREG bits):
  - rsv_en sets busy[rsv_addr].
  - Any committing write to addr clears busy[addr].
  - Reserve and write to the same addr in the same cycle: busy stays 1 (the new producer owns it).
  - Write to a non-busy register: busy stays 0, and the write still commits.
  - rd_busy reflects the post-update busy bit when BYPASS=1 and the pre-update bit when BYPASS=0, mirroring data.
- No X on outputs after the first reset edge. Addresses are always in range (NREG = 2**ADDR_W).

Decomposition:
- Package regfile_pkg holds:
  - constants DATA_W_DEF=32, ADDR_W_DEF=3, ZERO_IDX_DEF=7
  - a localparam function for packed-port slicing
  - reserved-bank indices for the future system bank: PC_IDX=6, CPSR_IDX=7
- One sub-module, regfile_scoreboard, contains the busy-bit array, set/clear priority and busy read muxes.
- Storage, write resolution and bypass stay in reg_file_mp.

Test Plan:
1. Reset, then read all 8 regs on both ports -> all rd_data=0 and rd_busy=0 one cycle after each address is applied.
2. Write value to each register:
   - wr0 r3=0xDEADBEEF, next cycle rd_addr0=3 -> rd_data0=0xDEADBEEF one cycle later.
   - wr1 r7=0x1234 then read r7 -> 0 (zero register).
3. Bypass: same cycle wr0 r2=0xA5A5A5A5 and rd_addr1=2, br_addr=2 -> next cycle rd_data1=br_data=0xA5A5A5A5 with BYPASS=1; old value 0 with BYPASS=0.
4. Write conflict: wr0 r4=0x11, wr1 r4=0x22 same cycle -> wr_conflict=1 for one cycle, then read r4 = 0x22. Same stimulus to r7 -> wr_conflict stays 0.
5. Scoreboard:
   - rsv r5 -> rd_busy for r5 = 1.
   - Same-cycle rsv r5 and wr0 r5=0x9 -> r5 stays busy, data 0x9.
   - wr1 r5=0xA -> busy clears, data 0xA.
6. Reset mid-operation: reserve r1, write r1=0xFF, assert rst_n=0 together with wr0 r1=0x55 -> next cycle all outputs 0, r1=0, busy[1]=0, and the write is discarded.
